// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared constants for the seven-segment page multiplexer:
//                display mode encodings and the default blank pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  // Display mode encodings; code 3 is reserved and treated as MANUAL.
  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_STEP   = 2'd1;
  localparam logic [1:0] MODE_AUTO   = 2'd2;

  // Segments are active-low, so an unlit digit is all ones.
  localparam int         SEG_W_DEFAULT = 7;
  localparam logic [SEG_W_DEFAULT-1:0] SEG_BLANK = {SEG_W_DEFAULT{1'b1}};

endpackage : display_pkg
`default_nettype wire

// File: rtl/page_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : page_sequencer
//  Description : Page index register with manual select, button stepping and
//                timed auto-rotation. Exposes both the registered page and the
//                value it will load at the next edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module page_sequencer
  import display_pkg::*;
#(
  parameter int PAGES       = 2,
  parameter int DWELL_TICKS = 5,
  parameter int PW          = $clog2(PAGES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [1:0]    mode,
  input  logic [PW-1:0] page_sel,
  input  logic          next_pg,
  output logic [PW-1:0] page_o,
  output logic [PW-1:0] page_next_o
);

  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [PW-1:0] LAST_PAGE  = PW'(PAGES - 1);
  localparam logic [DW-1:0] LAST_DWELL = DW'(DWELL_TICKS - 1);

  logic [PW-1:0] page_q, page_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [PW-1:0] w_page_adv;

  // Wrapping successor of the current page.
  assign w_page_adv = (page_q == LAST_PAGE) ? '0 : page_q + PW'(1);

  // Next page / dwell. Dwell is parked at zero outside AUTO, which also
  // gives AUTO a fresh dwell on entry while keeping the current page.
  always_comb begin
    page_d  = page_q;
    dwell_d = '0;
    case (mode)
      MODE_STEP: begin
        if (next_pg) page_d = w_page_adv;
      end
      MODE_AUTO: begin
        dwell_d = dwell_q;
        if (next_pg) begin
          // A button press wins over a coincident terminal tick: one advance.
          page_d  = w_page_adv;
          dwell_d = '0;
        end else if (tick) begin
          if (dwell_q == LAST_DWELL) begin
            page_d  = w_page_adv;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
      end
      default: begin
        // MANUAL and the reserved code: follow page_sel, clamped to range.
        if (page_sel > LAST_PAGE) page_d = LAST_PAGE;
        else                      page_d = page_sel;
      end
    endcase
  end

  // Page and dwell state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      page_q  <= '0;
      dwell_q <= '0;
    end else begin
      page_q  <= page_d;
      dwell_q <= dwell_d;
    end
  end

  assign page_o      = page_q;
  assign page_next_o = rst ? '0 : page_d;

endmodule : page_sequencer
`default_nettype wire

// File: rtl/display_page_mux.sv
`default_nettype none
// ============================================================================
//  Module      : display_page_mux
//  Description : Selects one of PAGES pre-encoded digit pages for the
//                seven-segment bank, with blink masking and registered outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_page_mux
  import display_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int PAGES       = 2,
  parameter int SEG_W       = 7,
  parameter int DWELL_TICKS = 5,
  parameter int BLINK_TICKS = 1,
  parameter int PW          = $clog2(PAGES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic [1:0]                   mode,
  input  logic [PW-1:0]                page_sel,
  input  logic                         next_pg,
  input  logic                         blink_en,
  input  logic [DIGITS-1:0]            blink_mask,
  input  logic [PAGES*DIGITS*SEG_W-1:0] page_in,
  output logic [DIGITS*SEG_W-1:0]      led,
  output logic [PW-1:0]                cur_page,
  output logic                         blink_phase
);

  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0]    LAST_BCNT = BW'(BLINK_TICKS - 1);
  localparam logic [SEG_W-1:0] BLANK     = {SEG_W{1'b1}};

  logic [PW-1:0]           w_page_next;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  logic                    phase_q, phase_d;
  logic [DIGITS*SEG_W-1:0] led_q, led_d;

  page_sequencer #(
    .PAGES       (PAGES),
    .DWELL_TICKS (DWELL_TICKS),
    .PW          (PW)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .mode        (mode),
    .page_sel    (page_sel),
    .next_pg     (next_pg),
    .page_o      (cur_page),
    .page_next_o (w_page_next)
  );

  // Blink half-period counter; disabling blink returns to the lit phase.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!blink_en) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (bcnt_q == LAST_BCNT) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  // Per-digit source select from the page being loaded this edge, so led and
  // cur_page always change on the same clock.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [SEG_W-1:0] w_raw;

    // Pick this digit out of the selected page.
    always_comb begin
      w_raw = page_in[gi*SEG_W +: SEG_W];
      for (int p = 0; p < PAGES; p++) begin
        if (w_page_next == PW'(p)) w_raw = page_in[(p*DIGITS+gi)*SEG_W +: SEG_W];
      end
    end

    assign led_d[gi*SEG_W +: SEG_W] =
      (blink_en && phase_d && blink_mask[gi]) ? BLANK : w_raw;
  end

  // Blink state and output registers; reset blanks the whole bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      led_q   <= {DIGITS{BLANK}};
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign led         = led_q;
  assign blink_phase = phase_q;

endmodule : display_page_mux
`default_nettype wire

// File: tb/tb_display_page_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_page_mux
//  Description : Directed self-checking bench for display_page_mux with a
//                reference model feeding an expected-value queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_page_mux;

  localparam int DIGITS = 8;
  localparam int PAGES  = 3;
  localparam int SEG_W  = 7;
  localparam int DWELL  = 5;
  localparam int BLINK  = 1;
  localparam int PW     = 2;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          tick;
  logic [1:0]                    mode;
  logic [PW-1:0]                 page_sel;
  logic                          next_pg;
  logic                          blink_en;
  logic [DIGITS-1:0]             blink_mask;
  logic [PAGES*DIGITS*SEG_W-1:0] page_in;
  logic [DIGITS*SEG_W-1:0]       led;
  logic [PW-1:0]                 cur_page;
  logic                          blink_phase;

  display_page_mux #(
    .DIGITS(DIGITS), .PAGES(PAGES), .SEG_W(SEG_W),
    .DWELL_TICKS(DWELL), .BLINK_TICKS(BLINK), .PW(PW)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .mode(mode), .page_sel(page_sel),
    .next_pg(next_pg), .blink_en(blink_en), .blink_mask(blink_mask),
    .page_in(page_in), .led(led), .cur_page(cur_page), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                   tag;
    logic [DIGITS*SEG_W-1:0] led;
    logic [PW-1:0]           pg;
    logic                    ph;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state
  int   m_page, m_dwell, m_bcnt;
  logic m_phase;

  function automatic int adv(input int p);
    return (p == PAGES-1) ? 0 : p + 1;
  endfunction

  function automatic logic [SEG_W-1:0] pg_digit(input int p, input int i);
    return page_in[(p*DIGITS+i)*SEG_W +: SEG_W];
  endfunction

  // Advance the model with the inputs as they stand, queue the expectation,
  // clock the DUT and compare.
  task automatic cyc(input string tag);
    exp_t e;
    if (rst) begin
      m_page = 0; m_dwell = 0; m_bcnt = 0; m_phase = 1'b0;
    end else begin
      case (mode)
        2'd1: begin
          if (next_pg) m_page = adv(m_page);
          m_dwell = 0;
        end
        2'd2: begin
          if (next_pg) begin
            m_page = adv(m_page); m_dwell = 0;
          end else if (tick) begin
            if (m_dwell == DWELL-1) begin m_page = adv(m_page); m_dwell = 0; end
            else m_dwell = m_dwell + 1;
          end
        end
        default: begin
          m_page  = (int'(page_sel) > PAGES-1) ? PAGES-1 : int'(page_sel);
          m_dwell = 0;
        end
      endcase
      if (!blink_en) begin
        m_bcnt = 0; m_phase = 1'b0;
      end else if (tick) begin
        if (m_bcnt == BLINK-1) begin m_bcnt = 0; m_phase = ~m_phase; end
        else m_bcnt = m_bcnt + 1;
      end
    end
    e.tag = tag;
    e.pg  = PW'(m_page);
    e.ph  = m_phase;
    for (int i = 0; i < DIGITS; i++) begin
      if (rst || (blink_en && m_phase && blink_mask[i]))
        e.led[i*SEG_W +: SEG_W] = '1;
      else
        e.led[i*SEG_W +: SEG_W] = pg_digit(m_page, i);
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    checks++;
    assert (led === e.led) else begin
      errors++;
      $error("FAIL %s led got %h exp %h", e.tag, led, e.led);
    end
    checks++;
    assert (cur_page === e.pg) else begin
      errors++;
      $error("FAIL %s cur_page got %0d exp %0d", e.tag, cur_page, e.pg);
    end
    checks++;
    assert (blink_phase === e.ph) else begin
      errors++;
      $error("FAIL %s blink_phase got %0b exp %0b", e.tag, blink_phase, e.ph);
    end
  endtask

  // Directed page check with a literal expectation.
  task automatic want_page(input string tag, input logic [PW-1:0] exp);
    checks++;
    assert (cur_page === exp) else begin
      errors++;
      $error("FAIL %s page got %0d exp %0d", tag, cur_page, exp);
    end
  endtask

  // Directed single-digit check with a literal expectation.
  task automatic want_digit(input string tag, input int i, input logic [SEG_W-1:0] exp);
    checks++;
    assert (led[i*SEG_W +: SEG_W] === exp) else begin
      errors++;
      $error("FAIL %s digit%0d got %h exp %h", tag, i, led[i*SEG_W +: SEG_W], exp);
    end
  endtask

  task automatic ticks(input int n, input string tag);
    tick = 1'b1;
    for (int k = 0; k < n; k++) cyc(tag);
    tick = 1'b0;
  endtask

  task automatic pulse(input string tag);
    next_pg = 1'b1;
    cyc(tag);
    next_pg = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; mode = 2'd0; page_sel = '0; next_pg = 1'b0;
    blink_en = 1'b0; blink_mask = '0;
    for (int p = 0; p < PAGES; p++)
      for (int i = 0; i < DIGITS; i++)
        page_in[(p*DIGITS+i)*SEG_W +: SEG_W] = SEG_W'(p*16 + i*2 + 1);

    // Reset
    cyc("reset0");
    cyc("reset1");
    want_page("reset_page", 2'd0);
    checks++;
    assert (led === {DIGITS*SEG_W{1'b1}}) else begin
      errors++;
      $error("FAIL reset_led got %h exp all ones", led);
    end
    rst = 1'b0;

    // MANUAL select and clamp
    page_sel = 2'd1; cyc("manual1");
    want_page("manual1_p", 2'd1);
    want_digit("manual1_d0", 0, 7'd17);
    page_sel = 2'd3; cyc("manual_clamp");
    want_page("manual_clamp_p", 2'd2);
    mode = 2'd3; page_sel = 2'd0; cyc("reserved_mode");
    want_page("reserved_p", 2'd0);

    // STEP
    mode = 2'd1; page_sel = 2'd2;
    pulse("step1"); want_page("step1_p", 2'd1);
    cyc("step_idle");
    pulse("step2"); want_page("step2_p", 2'd2);
    pulse("step3"); want_page("step3_p", 2'd0);
    ticks(6, "step_tick"); want_page("step_tick_p", 2'd0);

    // AUTO: terminal tick
    mode = 2'd2; cyc("auto_enter");
    ticks(4, "auto_t4"); want_page("auto_t4_p", 2'd0);
    ticks(1, "auto_t5"); want_page("auto_t5_p", 2'd1);
    // Button after three ticks, then a full dwell
    ticks(3, "auto_b3");
    pulse("auto_btn"); want_page("auto_btn_p", 2'd2);
    ticks(4, "auto_b4"); want_page("auto_b4_p", 2'd2);
    ticks(1, "auto_b5"); want_page("auto_b5_p", 2'd0);
    // Terminal tick coincident with button: single advance
    ticks(4, "auto_c4");
    tick = 1'b1; pulse("auto_coinc"); tick = 1'b0;
    want_page("auto_coinc_p", 2'd1);
    ticks(4, "auto_c_after4"); want_page("auto_c_after4_p", 2'd1);
    ticks(1, "auto_c_after5"); want_page("auto_c_after5_p", 2'd2);

    // Mid-rotation reset at page 1, dwell 3
    pulse("auto_to0"); pulse("auto_to1"); want_page("auto_to1_p", 2'd1);
    ticks(3, "auto_d3");
    rst = 1'b1; tick = 1'b1; next_pg = 1'b1; cyc("mid_rst"); rst = 1'b0; tick = 1'b0; next_pg = 1'b0;
    want_page("mid_rst_p", 2'd0);
    ticks(4, "post_rst4"); want_page("post_rst4_p", 2'd0);
    ticks(1, "post_rst5"); want_page("post_rst5_p", 2'd1);

    // Page data passes through with one cycle of latency
    mode = 2'd0; page_sel = 2'd1; cyc("pt_settle");
    page_in[(1*DIGITS+5)*SEG_W +: SEG_W] = 7'h2a; cyc("pt_change");
    want_digit("pt_change_d5", 5, 7'h2a);

    // Blink
    blink_en = 1'b1; blink_mask = 8'b0000_0011;
    ticks(1, "blink_on");
    want_digit("blink_on_d0", 0, 7'h7f);
    want_digit("blink_on_d2", 2, 7'd21);
    cyc("blink_hold");
    ticks(1, "blink_off_ph");
    want_digit("blink_off_d0", 0, 7'd17);
    ticks(1, "blink_on2");
    want_digit("blink_on2_d1", 1, 7'h7f);
    cyc("blink_hold2");
    blink_en = 1'b0; cyc("blink_drop");
    want_digit("blink_drop_d0", 0, 7'd17);
    want_digit("blink_drop_d1", 1, 7'd19);
    ticks(2, "blink_dis_tick");

    while (sbq.size() != 0) begin
      errors++;
      $error("FAIL scoreboard leftover %s got %0d exp %0d", sbq[0].tag, sbq.size(), 0);
      void'(sbq.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule : tb_display_page_mux
`default_nettype wire
